// File: rtl/mul_pkg.sv
// Shared types for the two-port multiplier arbiter: default width, FSM states, owner ids.
package mul_pkg;

    localparam int MUL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic owner_t;
    localparam owner_t OWN_REQ0 = 1'b0;
    localparam owner_t OWN_REQ1 = 1'b1;

endpackage

// File: rtl/mul_seq_core.sv
// Shift-and-add multiplier datapath: loads on start, then runs exactly W iterations.
module mul_seq_core #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p,
    output logic           done
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]   x_sh;
    logic [2*W-1:0] y_sh;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  count;
    logic           running;

    // done marks the edge that performs the final iteration
    assign done = running && (count == CW'(W - 1));
    assign p    = acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_sh    <= '0;
            y_sh    <= '0;
            acc     <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            x_sh    <= x;
            y_sh    <= (2*W)'(y);
            acc     <= '0;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (x_sh[0])
                acc <= acc + y_sh;
            x_sh  <= x_sh >> 1;
            y_sh  <= y_sh << 1;
            count <= count + CW'(1);
            if (done)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/mul_arb2.sv
// Round-robin arbiter and sequencer sharing one shift-and-add multiplier between two requesters.
module mul_arb2
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_x,
    input  logic [W-1:0]   req0_y,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_x,
    input  logic [W-1:0]   req1_y,
    output logic           rsp0_valid,
    input  logic           rsp0_ready,
    output logic [2*W-1:0] rsp0_p,
    output logic           rsp1_valid,
    input  logic           rsp1_ready,
    output logic [2*W-1:0] rsp1_p,
    output logic           busy
);

    state_t         state;
    owner_t         owner;
    owner_t         last_grant;
    logic           grant_valid;
    owner_t         grant_id;
    logic [2*W-1:0] core_p;
    logic           core_done;
    logic           owner_rsp_ready;

    // Ties go to whoever did not win last; a lone requester always wins
    assign grant_valid = (state == IDLE) && (req0_valid || req1_valid);
    assign grant_id    = (req0_valid && req1_valid) ? ~last_grant
                                                    : (req1_valid ? OWN_REQ1 : OWN_REQ0);

    assign req0_ready = grant_valid && (grant_id == OWN_REQ0);
    assign req1_ready = grant_valid && (grant_id == OWN_REQ1);

    mul_seq_core #(.W(W)) u_core (
        .clk   (clk),
        .reset (reset),
        .start (grant_valid),
        .x     ((grant_id == OWN_REQ1) ? req1_x : req0_x),
        .y     ((grant_id == OWN_REQ1) ? req1_y : req0_y),
        .p     (core_p),
        .done  (core_done)
    );

    assign owner_rsp_ready = (owner == OWN_REQ1) ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_REQ0;
            last_grant <= OWN_REQ1;
        end else begin
            case (state)
                IDLE: if (grant_valid) begin
                    owner      <= grant_id;
                    last_grant <= grant_id;
                    state      <= RUN;
                end
                RUN:  if (core_done) state <= RESP;
                RESP: if (owner_rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Products are zeroed outside their valid window
    assign rsp0_valid = (state == RESP) && (owner == OWN_REQ0);
    assign rsp1_valid = (state == RESP) && (owner == OWN_REQ1);
    assign rsp0_p     = rsp0_valid ? core_p : '0;
    assign rsp1_p     = rsp1_valid ? core_p : '0;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mul_arb2.sv
// Self-checking bench for mul_arb2: vector table, directed corner sequences, random vs. model.
module tb_mul_arb2;

    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_x, req0_y, req1_x, req1_y;
    logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [PW-1:0] rsp0_p, rsp1_p;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul_arb2 #(.W(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_p(rsp0_p),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_p(rsp1_p),
        .busy(busy)
    );

    typedef struct {
        bit            port;
        logic [W-1:0]  x;
        logic [W-1:0]  y;
        logic [PW-1:0] p;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy(input bit p);
        return p ? req1_ready : req0_ready;
    endfunction
    function automatic logic rv(input bit p);
        return p ? rsp1_valid : rsp0_valid;
    endfunction
    function automatic logic [PW-1:0] rp(input bit p);
        return p ? rsp1_p : rsp0_p;
    endfunction

    task automatic set_req(input bit p, input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
        if (p) begin req1_valid = v; req1_x = x; req1_y = y; end
        else   begin req0_valid = v; req0_x = x; req0_y = y; end
    endtask

    task automatic set_rrdy(input bit p, input logic v);
        if (p) rsp1_ready = v; else rsp0_ready = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_x = 0; req0_y = 0; req1_x = 0; req1_y = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Called just after the accept edge: checks W-cycle latency and product, then consumes
    task automatic wait_rsp(input bit p, input logic [PW-1:0] exp, input string name);
        int n = 0;
        while (!rv(p) && n < 40) begin
            step();
            n++;
        end
        chk({name, "_latency"}, n, W);
        chk({name, "_product"}, rp(p), exp);
        chk({name, "_other_rsp_valid"}, rv(!p), 0);
        set_rrdy(p, 1'b1);
        step();
        set_rrdy(p, 1'b0);
        chk({name, "_idle_after"}, busy, 0);
    endtask

    task automatic do_job(input bit p, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [PW-1:0] exp, input string name);
        set_req(p, 1'b1, x, y);
        #1;
        chk({name, "_ready_same_cycle"}, rdy(p), 1);
        step();
        set_req(p, 1'b0, 0, 0);
        wait_rsp(p, exp, name);
    endtask

    vec_t tbl[6];

    // Random-phase model state
    bit            m_busy, m_own, m_last, eg;
    int            m_cnt;
    logic [PW-1:0] m_p;

    initial begin
        tbl[0] = '{1'b0, 4'd3,  4'd5,  8'd15};
        tbl[1] = '{1'b1, 4'd15, 4'd15, 8'hE1};
        tbl[2] = '{1'b0, 4'd0,  4'd9,  8'd0};
        tbl[3] = '{1'b1, 4'd1,  4'd15, 8'd15};
        tbl[4] = '{1'b0, 4'd15, 4'd0,  8'd0};
        tbl[5] = '{1'b1, 4'd10, 4'd12, 8'd120};

        // Reset state
        do_reset();
        chk("reset_busy", busy, 0);
        chk("reset_rsp0_valid", rsp0_valid, 0);
        chk("reset_rsp1_valid", rsp1_valid, 0);
        chk("reset_rsp0_p", rsp0_p, 0);
        chk("reset_rsp1_p", rsp1_p, 0);
        chk("reset_req0_ready", req0_ready, 0);
        chk("reset_req1_ready", req1_ready, 0);

        // Single-requester vectors, including all-ones and zero-operand corners
        for (int i = 0; i < 6; i++)
            do_job(tbl[i].port, tbl[i].x, tbl[i].y, tbl[i].p, $sformatf("vec%0d", i));

        // Tie after reset goes to req0, then alternates
        do_reset();
        set_req(0, 1, 4'd2, 4'd3);
        set_req(1, 1, 4'd7, 4'd9);
        #1;
        chk("tie1_req0_ready", req0_ready, 1);
        chk("tie1_req1_ready", req1_ready, 0);
        step();
        set_req(0, 0, 0, 0);
        wait_rsp(0, 8'd6, "tie1_r0");
        chk("tie1_req1_ready_after", req1_ready, 1);
        step();
        set_req(1, 0, 0, 0);
        wait_rsp(1, 8'd63, "tie1_r1");
        set_req(0, 1, 4'd6, 4'd7);
        set_req(1, 1, 4'd5, 4'd5);
        #1;
        chk("tie2_req0_ready", req0_ready, 1);
        chk("tie2_req1_ready", req1_ready, 0);
        step();
        set_req(0, 0, 0, 0);
        wait_rsp(0, 8'd42, "tie2_r0");
        chk("tie2_req1_ready_after", req1_ready, 1);
        step();
        set_req(1, 0, 0, 0);
        wait_rsp(1, 8'd25, "tie2_r1");

        // Backpressure with a pending request on the other port
        do_reset();
        set_req(0, 1, 4'd5, 4'd6);
        step();
        set_req(0, 0, 0, 0);
        set_req(1, 1, 4'd3, 4'd3);
        begin
            int n = 0;
            while (!rsp0_valid && n < 40) begin step(); n++; end
            chk("bp_latency", n, W);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_rsp0_p", rsp0_p, 30);
            chk("bp_req1_ready", req1_ready, 0);
            chk("bp_busy", busy, 1);
            step();
        end
        rsp0_ready = 1;
        step();
        rsp0_ready = 0;
        chk("bp_req1_ready_release", req1_ready, 1);
        step();
        set_req(1, 0, 0, 0);
        wait_rsp(1, 8'd9, "bp_r1");

        // Reset pulsed mid-RUN abandons the job
        do_reset();
        set_req(1, 1, 4'd7, 4'd7);
        step();
        set_req(1, 0, 0, 0);
        step();
        reset = 1;
        step();
        reset = 0;
        chk("rst_run_busy", busy, 0);
        chk("rst_run_rsp0_valid", rsp0_valid, 0);
        chk("rst_run_rsp1_valid", rsp1_valid, 0);
        for (int i = 0; i < W + 3; i++) begin
            chk("rst_run_no_rsp", {rsp0_valid, rsp1_valid}, 0);
            step();
        end
        set_req(0, 1, 4'd4, 4'd4);
        set_req(1, 1, 4'd2, 4'd5);
        #1;
        chk("rst_tie_req0_ready", req0_ready, 1);
        chk("rst_tie_req1_ready", req1_ready, 0);
        step();
        set_req(0, 0, 0, 0);
        wait_rsp(0, 8'd16, "rst_r0");
        step();
        set_req(1, 0, 0, 0);
        wait_rsp(1, 8'd10, "rst_r1");

        // Random traffic against a transaction-level model
        do_reset();
        m_busy = 0; m_last = 1; m_cnt = 0; m_own = 0; m_p = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!req0_valid && $urandom_range(0, 2) == 0)
                set_req(0, 1, W'($urandom), W'($urandom));
            if (!req1_valid && $urandom_range(0, 2) == 0)
                set_req(1, 1, W'($urandom), W'($urandom));
            rsp0_ready = 1'($urandom_range(0, 1));
            rsp1_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_busy", busy, m_busy);
            if (!m_busy) begin
                eg = (req0_valid && req1_valid) ? !m_last : req1_valid;
                chk("rnd_req0_ready", req0_ready, (req0_valid || req1_valid) && !eg);
                chk("rnd_req1_ready", req1_ready, (req0_valid || req1_valid) && eg);
                chk("rnd_idle_rsp", {rsp0_valid, rsp1_valid}, 0);
                if (req0_valid || req1_valid) begin
                    m_p    = eg ? PW'(req1_x) * PW'(req1_y) : PW'(req0_x) * PW'(req0_y);
                    m_own  = eg;
                    m_last = eg;
                    m_cnt  = 0;
                    m_busy = 1;
                    step();
                    set_req(eg, 0, 0, 0);
                    continue;
                end
            end else begin
                chk("rnd_ready_while_busy", {req0_ready, req1_ready}, 0);
                chk("rnd_owner_rsp_valid", rv(m_own), m_cnt >= W);
                chk("rnd_other_rsp_valid", rv(!m_own), 0);
                if (m_cnt >= W) begin
                    chk("rnd_product", rp(m_own), m_p);
                    if (m_own ? rsp1_ready : rsp0_ready) m_busy = 0;
                end
                m_cnt++;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_arb2.md
# mul_arb2

Two-port arbiter and sequencer for a shared shift-and-add multiplier. Two requesters submit W×W unsigned multiply jobs over valid/ready handshakes. The block grants the single multiplier datapath round-robin, runs the operation for a fixed W iterations, and returns the 2W-bit product on the granting requester's response port. It sits between client logic and the multiplier, so clients never drive the multiplier's load, shift or reset controls directly.

## Interface
Parameters:
- W, 4, operand width; product width is 2W

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 has a job
- req0_ready  out  1  requester 0 job accepted this edge if valid
- req0_x, req0_y  in  W  requester 0 multiplier, multiplicand
- req1_valid, req1_ready, req1_x, req1_y: same roles for requester 1
- rsp0_valid  out  1  product for requester 0 available
- rsp0_ready  in  1  requester 0 consumes product
- rsp0_p  out  2W  product for requester 0
- rsp1_valid, rsp1_ready, rsp1_p: same roles for requester 1
- busy  out  1  state is not IDLE

## Operation
- FSM states:
  - IDLE: reqN_ready = (grant == N); all other readies are 0.
  - RUN: count 0..W-1.
  - RESP: holds the result.
- Grant (combinational, IDLE only):
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant.
- Accept (IDLE, granted valid & ready):
  - Capture x and y into the datapath.
  - Record owner; last_grant <= owner.
  - acc <= 0, count <= 0, go to RUN.
- RUN, each edge:
  - If x_sh[0] = 1: acc <= acc + y_sh.
  - x_sh >>= 1, y_sh <<= 1 (2W-bit), count++.
  - At count == W-1, go to RESP.
  - No early termination on zero operands.
- RESP:
  - rsp<owner>_valid = 1, rsp<owner>_p = acc. The other rsp_valid is 0.
  - On rsp<owner>_ready, go to IDLE. The non-owner's rsp_ready is ignored.
- Arithmetic: unsigned; acc is 2W bits and cannot overflow (max (2^W-1)^2).
- Protocol obligations on clients (not checked by the block):
  - Once reqN_valid is raised, it stays high and x/y stay stable until accepted.
  - rspN_p is valid only while rspN_valid is high; it holds its value until consumed.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins the first tie).
  - acc = 0; all rsp_valid, rsp_p = 0; all req_ready = 0 except as granted; busy = 0.
- Reset mid-RUN or mid-RESP: the job is abandoned with no response. The next cycle reflects reset values.
- Latency: accept on edge E0 → rsp_valid high from the cycle after edge E_W (W cycles).
- With rsp_ready held high, the response completes on E_{W+1} and ready returns in the cycle after it. Minimum issue period is W+2 cycles.
- Backpressure: rsp_valid and rsp_p are held indefinitely; both req_ready stay 0 meanwhile.
- A request arriving during RUN or RESP waits. Its priority is decided in IDLE by last_grant only, with no aging.

## Structure
- Package mul_pkg holds:
  - default W;
  - state encoding IDLE=2'd0, RUN=2'd1, RESP=2'd2;
  - owner encoding (1 bit).
- Sub-module mul_seq_core:
  - Ports: clk, reset, start, x, y → p, done.
  - Contains the shift registers, accumulator and iteration counter.
  - mul_arb2 keeps the FSM, grant logic and response routing.

## Test plan
1. After reset, req0 3×5 alone: req0_ready is high in the same cycle. rsp0_valid rises 4 cycles after accept with rsp0_p=15; rsp1_valid stays 0.
2. Both valid from IDLE after reset, req0 2×3 and req1 7×9: rsp0_p=6 completes first, then rsp1_p=63. A third pair held valid is served req0 then req1, alternating.
3. Corners: 15×15 → rsp_p=8'hE1 and 0×9 → 0. Both take exactly 4 cycles to rsp_valid.
4. Backpressure: rsp0_ready held low 5 cycles with req1 pending. rsp0_valid/rsp0_p stay stable, req1_ready stays 0 and busy stays 1. Releasing rsp0_ready leads to req1 accepted the next cycle.
5. reset pulsed while in RUN: next cycle busy=0 and all valids 0, and no response is emitted. A new tie then goes to req0 and completes correctly (e.g. 4×4=16).
